// File: rtl/if_fetch_unit.sv
// Instruction fetch: req/ack memory read, PC advance, FWFT fetch FIFO.
// Optional FETCH_ALIGN_CHK_EN blocks misaligned fetches with a sticky flag.
module if_fetch_unit #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    output logic          pc_en,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    input  logic          flush,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_out,
    output logic [AW-1:0] inst_pc,
    output logic          misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic IDLE = 1'b0;
    localparam logic WAIT = 1'b1;

    logic          state;
    logic          drop;
    logic [PW:0]   count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] mem_pc   [DEPTH];
    logic [DW-1:0] mem_inst [DEPTH];

    logic ack_ok;
    logic full;
    logic push;
    logic pop;
    logic pc_bad;
    logic issue;

`ifdef FETCH_ALIGN_CHK_EN
    assign pc_bad = (pc_in[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign <= 1'b0;
        end else if (flush) begin
            misalign <= 1'b0;
        end else if (state == IDLE && pc_bad) begin
            misalign <= 1'b1;
        end
    end
`else
    assign pc_bad   = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        ack_ok = (state == WAIT) & imem_ack & ~drop & ~flush;
        full   = (count == FULL);
        push   = ack_ok & ~full;
        pop    = inst_valid & inst_ready & ~flush;
        issue  = (state == IDLE) & ~flush & ~full
               & ~misalign & ~pc_bad;
    end

    assign pc_en      = ack_ok;
    assign inst_valid = (count != '0);
    assign inst_out   = mem_inst[rd_ptr];
    assign inst_pc    = mem_pc[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            drop      <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (issue) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc_in;
                        state     <= WAIT;
                    end
                end
                (state == WAIT): begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        drop     <= 1'b0;
                        state    <= IDLE;
                    end else if (flush) begin
                        // request stays up; its data is discarded on ack
                        drop <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]   <= imem_addr;
                mem_inst[wr_ptr] <= imem_rdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset) !(ack_ok && full)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus
// hand sequences for reset mid-fetch and the alignment check.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        misalign;

    logic        pc_ld;
    logic [31:0] ld_val;
    logic [31:0] pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.DEPTH(2), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_en      (pc_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .misalign   (misalign)
    );

    // PC register and memory model
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     pc <= '0;
        else if (pc_ld) pc <= ld_val;
        else if (pc_en) pc <= pc + 32'd4;
    end
    assign pc_in      = pc;
    assign imem_rdata = imem_ack ? (imem_addr ^ KEY) : '0;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        fl;
        logic        ld;
        logic        req;
        logic [31:0] addr;
        logic        pcen;
        logic        valid;
        logic [31:0] ipc;
    } vec_t;

    vec_t tv [26];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic r, input logic f,
                        input logic ld, input logic [31:0] lv);
        @(negedge clk);
        imem_ack   = a;
        inst_ready = r;
        flush      = f;
        pc_ld      = ld;
        ld_val     = lv;
        #1;
    endtask

    initial begin
        //        ack  rdy  fl   ld   req  addr      pcen valid ipc
        tv[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h000,1'b0,1'b0,32'h000};
        tv[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h000,1'b1,1'b0,32'h000};
        tv[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h000,1'b0,1'b1,32'h000};
        tv[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h004,1'b1,1'b0,32'h000};
        tv[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h004,1'b0,1'b1,32'h004};
        tv[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h008,1'b1,1'b1,32'h004};
        tv[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h008,1'b0,1'b1,32'h004};
        tv[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h008,1'b0,1'b1,32'h004};
        tv[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h008,1'b0,1'b1,32'h004};
        tv[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h008,1'b0,1'b1,32'h008};
        tv[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h00C,1'b0,1'b0,32'h000};
        tv[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h00C,1'b0,1'b0,32'h000};
        tv[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h00C,1'b0,1'b0,32'h000};
        tv[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h00C,1'b1,1'b0,32'h000};
        tv[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h00C,1'b0,1'b1,32'h00C};
        tv[15] = '{1'b0,1'b0,1'b1,1'b1,1'b1,32'h010,1'b0,1'b1,32'h00C};
        tv[16] = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h010,1'b0,1'b0,32'h000};
        tv[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h010,1'b0,1'b0,32'h000};
        tv[18] = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h200,1'b1,1'b0,32'h000};
        tv[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h200,1'b0,1'b1,32'h200};
        tv[20] = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h204,1'b1,1'b1,32'h200};
        tv[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h204,1'b0,1'b1,32'h204};
        tv[22] = '{1'b1,1'b1,1'b1,1'b0,1'b1,32'h208,1'b0,1'b1,32'h204};
        tv[23] = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h208,1'b0,1'b0,32'h000};
        tv[24] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h208,1'b0,1'b0,32'h000};
        tv[25] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h208,1'b0,1'b0,32'h000};

        reset      = 1'b0;
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        flush      = 1'b0;
        pc_ld      = 1'b0;
        ld_val     = 32'h200;

        repeat (2) @(negedge clk);
        #1;
        chk("rst req",      imem_req,   0);
        chk("rst addr",     imem_addr,  0);
        chk("rst pc_en",    pc_en,      0);
        chk("rst valid",    inst_valid, 0);
        chk("rst inst_out", inst_out,   0);
        chk("rst inst_pc",  inst_pc,    0);
        chk("rst misalign", misalign,   0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            reset      = 1'b1;
            imem_ack   = tv[i].ack;
            inst_ready = tv[i].rdy;
            flush      = tv[i].fl;
            pc_ld      = tv[i].ld;
            ld_val     = 32'h200;
            #1;
            chk($sformatf("v%0d req", i),   imem_req,   tv[i].req);
            chk($sformatf("v%0d addr", i),  imem_addr,  tv[i].addr);
            chk($sformatf("v%0d pc_en", i), pc_en,      tv[i].pcen);
            chk($sformatf("v%0d valid", i), inst_valid, tv[i].valid);
            chk($sformatf("v%0d mis", i),   misalign,   0);
            if (tv[i].valid) begin
                chk($sformatf("v%0d inst_pc", i), inst_pc, tv[i].ipc);
                chk($sformatf("v%0d inst_out", i), inst_out,
                    tv[i].ipc ^ KEY);
            end
        end

        // reset while a fetch is pending, then a late ack
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        flush    = 1'b0;
        pc_ld    = 1'b0;
        #1;
        chk("async rst req",   imem_req,   0);
        chk("async rst valid", inst_valid, 0);
        @(negedge clk);
        reset    = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("late ack pc_en", pc_en,      0);
        chk("late ack req",   imem_req,   0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("post rst req",   imem_req,   1);
        chk("post rst addr",  imem_addr,  0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("post rst pc_en", pc_en,      1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h6);
        chk("ld6 req",        imem_req,   0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("pc6 idle req",   imem_req,   0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("mis set",        misalign,   1);
        chk("mis no req",     imem_req,   0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("mis sticky",     misalign,   1);
        chk("mis still idle", imem_req,   0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8);
        chk("mis pre clr",    misalign,   1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("mis cleared",    misalign,   0);
        chk("mis clr req",    imem_req,   0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("realign req",    imem_req,   1);
        chk("realign addr",   imem_addr,  32'h8);
`else
        chk("unaligned req",  imem_req,   1);
        chk("unaligned addr", imem_addr,  32'h6);
        chk("unaligned mis",  misalign,   0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("unaligned pc_en", pc_en,     1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Consumer end of the program-counter interface. Takes the current PC value, issues a req/ack read to instruction memory, and advances the PC register through its `en` input only after a successful fetch.
- Fetched {pc, instruction} pairs are buffered in a small FIFO. The FIFO feeds the IF/ID stage through a valid/ready handshake.
- Supports branch/jump flush.

Parameters:
- DEPTH, 2, number of FIFO entries (power of 2, ≥2)
- AW, 32, address/PC width
- DW, 32, instruction width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- pc_in  input  AW  current PC from PC register output
- pc_en  output  1  advance PC; one-cycle pulse, drives PC `en`
- imem_req  output  1  instruction memory read request
- imem_addr  output  AW  read address, stable while imem_req=1
- imem_ack  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  DW  instruction word
- flush  input  1  discard buffered and in-flight fetches
- inst_valid  output  1  FIFO head valid
- inst_ready  input  1  IF/ID accepts head
- inst_out  output  DW  head instruction
- inst_pc  output  AW  PC of head instruction
- misalign  output  1  sticky misaligned-PC flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous), outputs and state:
  - imem_req=0, imem_addr=0, pc_en=0
  - inst_valid=0, inst_out=0, inst_pc=0, misalign=0
  - FIFO empty (count=0), state=IDLE, drop=0
- FSM states: IDLE, WAIT.
- IDLE:
  - If flush=0 and count<DEPTH: register imem_addr<=pc_in, imem_req<=1, go to WAIT.
  - Otherwise stay in IDLE with imem_req=0.
- WAIT:
  - Hold imem_req=1 and imem_addr constant until imem_ack=1.
  - On the ack cycle, if drop=0:
    - Push {imem_addr, imem_rdata} into FIFO.
    - pc_en=1 combinationally in that cycle, so the PC and FIFO update on the same edge.
    - Next state IDLE with imem_req=0.
  - On the ack cycle, if drop=1: discard data, pc_en=0, clear drop, go to IDLE.
- pc_en:
  - Equals (state==WAIT & imem_ack & ~drop & ~flush).
  - Never asserted outside that term.
- Throughput and latency:
  - Maximum one fetch per 2 cycles (IDLE+WAIT) with a zero-wait memory.
  - Ack-to-inst_valid latency: 1 cycle. inst_valid rises on the edge that pushes.
- FIFO:
  - First-word fall-through; inst_valid = (count!=0). inst_out/inst_pc show the head entry.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - Issue is gated on count<DEPTH at IDLE, and only one fetch is in flight. Push into a full FIFO is therefore impossible.
  - Overflow guard: a push attempt while full is ignored. Verify with an assertion.
- inst_valid/inst_out/inst_pc stay stable while inst_valid=1 & inst_ready=0.
- flush (highest priority; applies in the same cycle it is sampled):
  - FIFO cleared (count=0, pointers=0). inst_valid=0 the next cycle. Any same-cycle push/pop is cancelled.
  - In IDLE: no issue that cycle.
  - In WAIT without ack: req stays asserted (no abort), drop<=1.
  - In WAIT with ack: data discarded, pc_en=0, go to IDLE.
  - Flush in consecutive cycles: idempotent.
- New PC after flush: the external branch logic loads the PC. This block fetches pc_in at the first IDLE cycle with flush=0.
- Reset mid-WAIT: req drops immediately (async). A late ack after reset release is ignored, because state=IDLE.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - In IDLE, if pc_in[1:0]!=2'b00: no request issued, misalign<=1 (sticky).
  - While misalign=1, no further fetches are issued.
  - Cleared by reset or flush; flush then permits normal issue.
- Undefined:
  - Address issued unchanged regardless of low bits.
  - misalign tied to 0.

Test Plan:
- Reset behaviour: reset=0 then released, pc_in=0x00000000, zero-wait ack, inst_ready=1 -> first imem_req on cycle 1 after release with addr 0x0. pc_en pulses with ack. inst_valid=1 next cycle with inst_pc=0x0, inst_out=rdata.
- Back-pressure: inst_ready=0, PC increments by 4 per pc_en, DEPTH=2 -> exactly 2 fetches (0x0, 0x4), then imem_req stays 0. Raise inst_ready -> entries pop in order 0x0, 0x4, then fetch of 0x8 resumes.
- Wait states: imem_ack delayed 3 cycles -> imem_addr/imem_req stable for all 3 cycles. pc_en asserts only in the ack cycle, exactly once.
- Flush in WAIT: flush during the pending fetch of 0x10 with 1 entry buffered -> FIFO empty next cycle. Ack for 0x10 produces no push and pc_en=0. The next request uses the new pc_in=0x200.
- Push/pop same cycle: FIFO holds 1 entry with inst_ready=1 while ack arrives -> count stays 1, head advances to the new entry, no loss or duplication.
- FETCH_ALIGN_CHK_EN: pc_in=0x00000006 -> no imem_req, misalign=1. Then flush with pc_in=0x8 -> misalign=0 and fetch of 0x8 issued.
